// File: rtl/pb_conditioner.sv
// Pushbutton conditioner: per-channel 2-flop synchroniser, counter debounce,
// registered press level, one-cycle press pulse and optional hold-to-repeat.

module pb_channel #(
  parameter int CNT_W           = 8,
  parameter int ACTIVE_LOW_IN   = 1,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 5,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic pb_raw,
  output logic level,
  output logic pulse
);
  // Raw pin level that means "not pressed"; the sync chain resets to it.
  localparam logic IDLE_LVL = (ACTIVE_LOW_IN != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync_q;
  logic             p;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, pulse_nxt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sync_q <= {2{IDLE_LVL}};
    else         sync_q <= {sync_q[0], pb_raw};
  end

  assign p = sync_q[1] ^ IDLE_LVL;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

  // Every state change clears the counter, so each state times from its own entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    level_nxt = level;
    pulse_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (p) state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (!p) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          state_nxt = RELEASE_DB;
          cnt_nxt   = '0;
        end else if (!REPEAT_EN) begin
          cnt_nxt = cnt;
        end else if (cnt == RD_LAST) begin
          state_nxt = REPEAT;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end
      end
      REPEAT: begin
        if (!p) begin
          state_nxt = RELEASE_DB;
          cnt_nxt   = '0;
        end else if (cnt == RP_LAST) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end
      end
      RELEASE_DB: begin
        // A bounce back to pressed resumes HELD silently; the repeat timer restarts.
        if (p) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end
endmodule

module pb_conditioner #(
  parameter int              N_PB            = 4,
  parameter int              ACTIVE_LOW_IN   = 1,
  parameter int              DEBOUNCE_CYCLES = 1_000_000,
  parameter int              REPEAT_DELAY    = 25_000_000,
  parameter int              REPEAT_PERIOD   = 5_000_000,
  parameter logic [N_PB-1:0] REPEAT_MASK     = '0
) (
  input  logic            CLK_50,
  input  logic            reset,
  input  logic [N_PB-1:0] pb_in,
  output logic [N_PB-1:0] pb_level,
  output logic [N_PB-1:0] pb_pulse
);
  localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  for (genvar i = 0; i < N_PB; i++) begin : g_ch
    pb_channel #(
      .CNT_W          (CNT_W),
      .ACTIVE_LOW_IN  (ACTIVE_LOW_IN),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .gclk  (CLK_50),
      .grst_n(reset),
      .pb_raw(pb_in[i]),
      .level (pb_level[i]),
      .pulse (pb_pulse[i])
    );
  end
endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner: a run-length/elapsed-time model of each
// button predicts pb_level/pb_pulse every cycle; literal pulse edges pin the model.

module tb_pb_conditioner;
  localparam int          D    = 8;
  localparam int          RD   = 20;
  localparam int          RP   = 5;
  localparam logic [3:0]  MASK = 4'b0010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] pb_in = 4'hF;
  logic [3:0] pb_level, pb_pulse;

  int total = 0;
  int bad   = 0;

  pb_conditioner #(
    .N_PB(4), .ACTIVE_LOW_IN(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .CLK_50  (clk),
    .reset   (rst_n),
    .pb_in   (pb_in),
    .pb_level(pb_level),
    .pb_pulse(pb_pulse)
  );

  always #5 clk = ~clk;

  // Model: pressed samples reach the decision point 3 edges after being driven.
  int         ecnt = 0;
  int         base = 0;
  logic [3:0] m_s1, m_s2, m_last, m_lvl, m_pls;
  int         m_run[4];
  int         m_seg[4];
  int         m_pe[4][16];
  int         m_pn[4];
  int         m_fall[4];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d want %0d", nm, ecnt - base, act, exp);
    end
  endtask

  task automatic model_clear_state();
    m_s1 = '0; m_s2 = '0; m_last = '0; m_lvl = '0; m_pls = '0;
    for (int c = 0; c < 4; c++) begin
      m_run[c] = 0;
      m_seg[c] = 0;
    end
  endtask

  task automatic begin_test();
    base = ecnt + 1;
    for (int c = 0; c < 4; c++) begin
      m_pn[c]   = 0;
      m_fall[c] = -1;
    end
  endtask

  task automatic model_edge();
    logic [3:0] p;
    if (!rst_n) begin
      model_clear_state();
      return;
    end
    p    = m_s2;
    m_s2 = m_s1;
    m_s1 = ~pb_in;
    for (int c = 0; c < 4; c++) begin
      m_pls[c] = 1'b0;
      if (p[c] == m_last[c]) m_run[c]++;
      else                   m_run[c] = 1;
      m_last[c] = p[c];
      if (!m_lvl[c]) begin
        if (p[c] && m_run[c] == D + 1) begin
          m_lvl[c] = 1'b1;
          m_pls[c] = 1'b1;
          m_seg[c] = ecnt;
        end
      end else if (!p[c]) begin
        if (m_run[c] == D + 1) begin
          m_lvl[c] = 1'b0;
          if (m_fall[c] < 0) m_fall[c] = ecnt - base;
        end
      end else if (m_run[c] == 1) begin
        m_seg[c] = ecnt;
      end else if (MASK[c] && (ecnt - m_seg[c]) >= RD && ((ecnt - m_seg[c] - RD) % RP) == 0) begin
        m_pls[c] = 1'b1;
      end
      if (m_pls[c] && m_pn[c] < 16) begin
        m_pe[c][m_pn[c]] = ecnt - base;
        m_pn[c]++;
      end
    end
  endtask

  // One clock: model the edge, drive the next inputs, then compare mid-cycle.
  task automatic tick(input logic [3:0] v, input logic r);
    @(posedge clk);
    ecnt++;
    model_edge();
    #1;
    pb_in = v;
    rst_n = r;
    if (!r) model_clear_state();
    @(negedge clk);
    chk("cyc_level", int'(pb_level), int'(m_lvl));
    chk("cyc_pulse", int'(pb_pulse), int'(m_pls));
  endtask

  task automatic do_reset();
    tick(4'hF, 1'b0);
    tick(4'hF, 1'b0);
    tick(4'hF, 1'b1);
    tick(4'hF, 1'b1);
  endtask

  initial begin
    model_clear_state();
    begin_test();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_level", int'(pb_level), 0);
    chk("reset_pulse", int'(pb_pulse), 0);
    do_reset();

    // 1: ch0 held from edge 0
    begin_test();
    for (int k = 0; k < 60; k++) tick(4'hE, 1'b1);
    chk("t1_npulse", m_pn[0], 1);
    chk("t1_edge", m_pe[0][0], 11);
    chk("t1_level", int'(pb_level[0]), 1);

    // 2: ch0 bouncing every 3 cycles, then stable low from edge 30
    do_reset();
    begin_test();
    for (int k = 0; k < 50; k++) tick((k >= 30 || ((k / 3) % 2) == 0) ? 4'hE : 4'hF, 1'b1);
    chk("t2_npulse", m_pn[0], 1);
    chk("t2_edge", m_pe[0][0], 41);

    // 3: ch1 repeat channel, pressed for edges 0..57
    do_reset();
    begin_test();
    for (int k = 0; k < 80; k++) tick((k < 58) ? 4'hD : 4'hF, 1'b1);
    chk("t3_npulse", m_pn[1], 7);
    chk("t3_e0", m_pe[1][0], 11);
    chk("t3_e1", m_pe[1][1], 31);
    chk("t3_e2", m_pe[1][2], 36);
    chk("t3_e6", m_pe[1][6], 56);
    chk("t3_fall", m_fall[1], 69);
    chk("t3_level", int'(pb_level[1]), 0);

    // 4: ch0 held, 3-cycle glitch at edge 30, release at edge 50
    do_reset();
    begin_test();
    for (int k = 0; k < 80; k++) tick(((k >= 30 && k <= 32) || k >= 50) ? 4'hF : 4'hE, 1'b1);
    chk("t4_npulse", m_pn[0], 1);
    chk("t4_fall", m_fall[0], 61);
    chk("t4_level", int'(pb_level[0]), 0);

    // 5: reset asserted while ch0 is held; button stays held through reset release
    do_reset();
    begin_test();
    for (int k = 0; k < 20; k++) tick(4'hE, 1'b1);
    chk("t5_level_pre", int'(pb_level[0]), 1);
    #1 rst_n = 1'b0;
    model_clear_state();
    #1;
    chk("t5_rst_level", int'(pb_level), 0);
    chk("t5_rst_pulse", int'(pb_pulse), 0);
    tick(4'hE, 1'b0);
    tick(4'hE, 1'b0);
    begin_test();
    for (int k = 0; k < 30; k++) tick(4'hE, 1'b1);
    chk("t5_npulse", m_pn[0], 1);
    chk("t5_edge", m_pe[0][0], 11);

    // 6: ch2 and ch3 pressed on the same edge
    do_reset();
    begin_test();
    for (int k = 0; k < 30; k++) tick(4'h3, 1'b1);
    chk("t6_n2", m_pn[2], 1);
    chk("t6_n3", m_pn[3], 1);
    chk("t6_e2", m_pe[2][0], 11);
    chk("t6_e3", m_pe[3][0], 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
